// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared types for the SSD1306 SPI byte streamer
package ssd1306_pkg;

  localparam int STREAM_WIDTH = 8;
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } e_stream_state;

  typedef struct packed {
    logic                    last;
    logic                    dc;
    logic [STREAM_WIDTH-1:0] data;
  } s_stream_entry;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, full and empty flags
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_byte_streamer.sv
// rtl/spi_byte_streamer.sv - queues tagged display bytes and hands them to the SPI master with D/C
module spi_byte_streamer
  import ssd1306_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic                       wr_valid_in,
  output logic                       wr_ready_out,
  input  logic [WIDTH-1:0]           wr_data_in,
  input  logic                       wr_dc_in,
  input  logic                       wr_last_in,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       busy_out,
  output logic                       spi_start_out,
  output logic                       spi_deactivate_cs_out,
  output logic [WIDTH-1:0]           spi_data_out,
  input  logic                       spi_done_in,
  output logic                       dc_out
);

  localparam int AW = $clog2(DEPTH);

  logic             full;
  logic             empty;
  logic [AW:0]      level;
  logic [WIDTH+1:0] head;
  logic             push;
  logic             pop;

  e_stream_state    state_q;
  logic             start_q;
  logic             deact_q;
  logic             dc_q;
  logic [WIDTH-1:0] data_q;
  logic             retry_q;

  assign push = wr_valid_in & ~full;
  assign pop  = (state_q == S_IDLE) & ~empty & spi_done_in;

  sync_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (reset_n_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({wr_last_in, wr_dc_in, wr_data_in}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      deact_q <= 1'b1;
      dc_q    <= DC_CMD;
      data_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            data_q  <= head[WIDTH-1:0];
            dc_q    <= head[WIDTH];
            // Release CS when the queue runs dry, not only on a tagged last byte.
            deact_q <= head[WIDTH+1] | ((level == (AW+1)'(1)) & ~push);
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          retry_q <= 1'b0;
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!spi_done_in) begin
            state_q <= S_WAIT_HIGH;
          end else if (retry_q) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            retry_q <= 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (spi_done_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_ready_out          = ~full;
  assign level_out             = level;
  assign busy_out              = (state_q != S_IDLE) | (level != '0);
  assign spi_start_out         = start_q;
  assign spi_deactivate_cs_out = deact_q;
  assign spi_data_out          = data_q;
  assign dc_out                = dc_q;

endmodule

// File: tb/tb_spi_byte_streamer.sv
// tb/tb_spi_byte_streamer.sv - directed bench for spi_byte_streamer with a simple SPI master model
module tb_spi_byte_streamer;
  import ssd1306_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       wr_dc = 1'b0;
  logic       wr_last = 1'b0;
  logic [4:0] level;
  logic       busy;
  logic       spi_start;
  logic       spi_deact;
  logic [7:0] spi_data;
  logic       spi_done;
  logic       dc;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  logic hold_busy = 1'b0;
  logic model_busy;
  int   model_cnt;
  logic [8:0] held;
  s_stream_entry log_q[$];
  s_stream_entry exp_q[$];
  logic stall_seen;
  int   stall_level;

  always #5 clk = ~clk;

  spi_byte_streamer #(.WIDTH(8), .DEPTH(16)) dut (
    .clk_in                (clk),
    .reset_n_in            (rst_n),
    .wr_valid_in           (wr_valid),
    .wr_ready_out          (wr_ready),
    .wr_data_in            (wr_data),
    .wr_dc_in              (wr_dc),
    .wr_last_in            (wr_last),
    .level_out             (level),
    .busy_out              (busy),
    .spi_start_out         (spi_start),
    .spi_deactivate_cs_out (spi_deact),
    .spi_data_out          (spi_data),
    .spi_done_in           (spi_done),
    .dc_out                (dc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI master model: 8 bits at one sck per 2 clocks, done low while shifting.
  assign spi_done = !model_busy && !hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_busy) begin
      if (model_cnt == 1) begin
        model_busy <= 1'b0;
        check("hold_dc_data", {23'd0, dc, spi_data}, {23'd0, held});
      end
      model_cnt <= model_cnt - 1;
    end else if (spi_start && spi_done) begin
      model_busy <= 1'b1;
      model_cnt  <= 16;
      held       <= {dc, spi_data};
      log_q.push_back('{last: spi_deact, dc: dc, data: spi_data});
    end
  end

  always @(posedge clk) if (spi_start) starts++;

  task automatic push_byte(input logic [7:0] d, input logic dcv, input logic last);
    int guard = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_dc    = dcv;
    wr_last  = last;
    while (!wr_ready && guard < 300) begin
      if (!stall_seen) begin
        stall_seen  = 1'b1;
        stall_level = int'(level);
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || !spi_done) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), {22'd0, log_q[i]}, {22'd0, exp_q[i]});
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0;
    stall_seen  = 1'b0;
    stall_level = 0;
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", spi_start, 0);
    check("rst_deact", spi_deact, 1);
    check("rst_data", spi_data, 0);
    check("rst_dc", dc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command byte: start two cycles after the push.
    push_byte(8'hAE, DC_CMD, 1'b1);
    check("lat_level1", level, 1);
    check("lat_start_early", spi_start, 0);
    @(negedge clk);
    check("lat_start", spi_start, 1);
    check("lat_data", spi_data, 8'hAE);
    check("lat_dc", dc, 0);
    check("lat_deact", spi_deact, 1);
    check("lat_level0", level, 0);
    @(negedge clk);
    check("lat_start_one", spi_start, 0);
    wait_idle();
    exp_q.push_back('{last: 1'b1, dc: 1'b0, data: 8'hAE});
    compare_log("single");

    // 20 bytes into a 16-deep FIFO.
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h30 + 8'(i), 1'(i), i == 19);
      exp_q.push_back('{last: (i == 19), dc: 1'(i), data: 8'h30 + 8'(i)});
    end
    check("stall_seen", stall_seen, 1);
    check("stall_level", stall_level, 16);
    wait_idle();
    compare_log("burst");

    // D/C sequence with CS held until the final data byte.
    push_byte(8'h21, DC_CMD, 1'b0);
    push_byte(8'h00, DC_CMD, 1'b0);
    push_byte(8'hFF, DC_DATA, 1'b1);
    wait_idle();
    exp_q.push_back('{last: 1'b0, dc: 1'b0, data: 8'h21});
    exp_q.push_back('{last: 1'b0, dc: 1'b0, data: 8'h00});
    exp_q.push_back('{last: 1'b1, dc: 1'b1, data: 8'hFF});
    compare_log("dcseq");

    // Empty-queue release, then push coinciding with the pop of a lone byte.
    push_byte(8'h55, DC_DATA, 1'b0);
    wait_idle();
    push_byte(8'h66, DC_DATA, 1'b0);
    push_byte(8'h77, DC_DATA, 1'b0);
    wait_idle();
    exp_q.push_back('{last: 1'b1, dc: 1'b1, data: 8'h55});
    exp_q.push_back('{last: 1'b0, dc: 1'b1, data: 8'h66});
    exp_q.push_back('{last: 1'b1, dc: 1'b1, data: 8'h77});
    compare_log("empty");

    // SPI busy: nothing may start while done is low.
    hold_busy = 1'b1;
    s0 = starts;
    push_byte(8'hA1, DC_CMD, 1'b0);
    push_byte(8'hA2, DC_CMD, 1'b0);
    push_byte(8'hA3, DC_CMD, 1'b1);
    repeat (8) @(negedge clk);
    check("hold_level", level, 3);
    check("hold_nostart", starts - s0, 0);
    check("hold_busy", busy, 1);
    hold_busy = 1'b0;
    @(negedge clk);
    check("hold_pop_level", level, 2);
    check("hold_pop_start", spi_start, 1);
    check("hold_pop_data", spi_data, 8'hA1);
    wait_idle();
    exp_q.push_back('{last: 1'b0, dc: 1'b0, data: 8'hA1});
    exp_q.push_back('{last: 1'b0, dc: 1'b0, data: 8'hA2});
    exp_q.push_back('{last: 1'b1, dc: 1'b0, data: 8'hA3});
    compare_log("hold");

    // Asynchronous reset mid-transfer with five bytes queued.
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i), DC_DATA, 1'b0);
    check("pre_rst_level", level, 5);
    check("pre_rst_inflight", model_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check("arst_start", spi_start, 0);
    check("arst_deact", spi_deact, 1);
    check("arst_data", spi_data, 0);
    check("arst_dc", dc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    s0 = starts;
    repeat (10) @(negedge clk);
    check("post_rst_nostart", starts - s0, 0);
    check("post_rst_ready", wr_ready, 1);
    push_byte(8'hC3, DC_CMD, 1'b1);
    wait_idle();
    exp_q.push_back('{last: 1'b1, dc: 1'b0, data: 8'hC3});
    compare_log("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
